pmp_controller: RTL and testbench

Memory-mapped controller that sequences the pattern-matching peripheral. Sits on the CPU data bus beside dmem and outperiph, decoding its own address window. Software loads a pattern and pushes text words into a FIFO. The controller feeds text one byte per cycle through a sliding comparison window and counts every (overlapping) occurrence of the pattern.

---
 rtl/pmp_pkg.sv | 30 +++
 rtl/pmp_controller_if.sv | 10 +
 rtl/pmp_match_window.sv | 42 ++++
 rtl/pmp_controller.sv | 176 +++++++++++++++++
 tb/tb_pmp_controller.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pmp_pkg.sv
// Shared definitions for the pattern-matching peripheral controller:
// register map, CTRL/STATUS bit positions, FSM encoding, max pattern length.
package pmp_pkg;
  localparam int MAX_PAT = 8;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_PAT_LO  = 5'h04;
  localparam logic [4:0] OFF_PAT_HI  = 5'h08;
  localparam logic [4:0] OFF_TEXT    = 5'h0C;
  localparam logic [4:0] OFF_STATUS  = 5'h10;
  localparam logic [4:0] OFF_COUNT   = 5'h14;
  localparam logic [4:0] OFF_LASTPOS = 5'h18;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_STOP    = 2;
  localparam int CTRL_LEN_LSB = 8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SCAN  = 2'd2
  } pmp_state_e;
endpackage

// File: rtl/pmp_controller_if.sv
// CPU data-bus slice seen by the pattern-matching controller.
interface pmp_controller_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  modport master (output daddr, output dwdata, output dwe, input drdata);
  modport slave  (input daddr, input dwdata, input dwe, output drdata);
endinterface

// File: rtl/pmp_match_window.sv
// 8-byte sliding window with saturating fill count and a LEN-masked compare.
// o_match is qualified by a byte having been shifted in on the previous edge.
module pmp_match_window import pmp_pkg::*; (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              i_byte,
  input  logic                    i_valid,
  input  logic [MAX_PAT-1:0][7:0] i_pat,
  input  logic [2:0]              i_len_m1,
  input  logic                    i_clear,
  output logic                    o_match
);
  logic [MAX_PAT-1:0][7:0] r_win;
  logic [3:0]              r_seen;
  logic                    r_vld;
  logic                    w_eq;

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_win  <= '0;
      r_seen <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= i_valid;
      if (i_valid) begin
        r_win  <= {r_win[MAX_PAT-2:0], i_byte};
        r_seen <= (r_seen == 4'd8) ? r_seen : r_seen + 4'd1;
      end
    end
  end

  // r_win[0] is newest; pattern byte 0 pairs with the oldest byte of the match.
  always_comb begin
    w_eq = 1'b1;
    for (int j = 0; j < MAX_PAT; j++) begin
      if ((3'(j) <= i_len_m1) && (r_win[i_len_m1 - 3'(j)] != i_pat[j]))
        w_eq = 1'b0;
    end
  end

  assign o_match = r_vld && (r_seen > {1'b0, i_len_m1}) && w_eq;
endmodule

// File: rtl/pmp_controller.sv
// Memory-mapped sequencer: text FIFO, IDLE/FETCH/SCAN FSM, match counters.
// Define PMP_LASTPOS_EN to build the LASTPOS register; otherwise 0x18 reads 0.
module pmp_controller import pmp_pkg::*; #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0500,
  parameter int          FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  pmp_controller_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  pmp_state_e     r_state, w_state_nxt;
  logic           r_run;
  logic [2:0]     r_len_m1;
  logic [31:0]    r_pat_lo, r_pat_hi;
  logic [31:0]    r_count, r_bidx;
  logic           r_ovf;
  logic [31:0]    r_word;
  logic [1:0]     r_k;
  logic [31:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_cnt;
`ifdef PMP_LASTPOS_EN
  logic [31:0]    r_lastpos;
`endif

  logic        w_sel, w_wr, w_wr_ctrl, w_clear, w_busy;
  logic        w_full, w_empty, w_push, w_pop, w_shift, w_match;
  logic [4:0]  w_off;
  logic [31:0] w_rdata;

  assign w_sel     = (bus.daddr[31:5] == BASE_ADDR[31:5]);
  assign w_off     = bus.daddr[4:0];
  assign w_wr      = w_sel && (bus.dwe == 4'hF);
  assign w_wr_ctrl = w_wr && (w_off == OFF_CTRL);
  assign w_clear   = w_wr_ctrl && bus.dwdata[CTRL_CLEAR];
  assign w_busy    = (r_state != S_IDLE);
  assign w_full    = (r_cnt == DEPTH_C);
  assign w_empty   = (r_cnt == '0);
  assign w_push    = w_wr && (w_off == OFF_TEXT) && !w_full;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE:  if (r_run) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (!r_run) w_state_nxt = S_IDLE;
        else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_shift = 1'b1;
        if (r_k == 2'd3) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_clear) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
      w_shift     = 1'b0;
    end
  end

  // Control and pattern registers; CLEAR keeps PAT/LEN, busy blocks updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run    <= 1'b0;
      r_len_m1 <= '0;
      r_pat_lo <= '0;
      r_pat_hi <= '0;
    end else if (w_clear) begin
      r_run <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        if (bus.dwdata[CTRL_STOP])       r_run <= 1'b0;
        else if (bus.dwdata[CTRL_START]) r_run <= 1'b1;
        if (!w_busy) r_len_m1 <= bus.dwdata[CTRL_LEN_LSB +: 3];
      end
      if (w_wr && !w_busy && (w_off == OFF_PAT_LO)) r_pat_lo <= bus.dwdata;
      if (w_wr && !w_busy && (w_off == OFF_PAT_HI)) r_pat_hi <= bus.dwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.dwdata;
  end

  always_ff @(posedge clk) begin
    if (!reset || w_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_wr && (w_off == OFF_TEXT) && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || w_clear) begin
      r_word <= '0;
      r_k    <= '0;
    end else if (w_pop) begin
      r_word <= r_mem[r_rptr];
      r_k    <= '0;
    end else if (w_shift) begin
      r_word <= {8'h00, r_word[31:8]};
      r_k    <= r_k + 2'd1;
    end
  end

  pmp_match_window u_win (
    .clk      (clk),
    .reset    (reset),
    .i_byte   (r_word[7:0]),
    .i_valid  (w_shift),
    .i_pat    ({r_pat_hi, r_pat_lo}),
    .i_len_m1 (r_len_m1),
    .i_clear  (w_clear),
    .o_match  (w_match)
  );

  // r_bidx already counts the byte being matched, so its index is r_bidx-1.
  always_ff @(posedge clk) begin
    if (!reset || w_clear) begin
      r_count <= '0;
      r_bidx  <= '0;
`ifdef PMP_LASTPOS_EN
      r_lastpos <= '0;
`endif
    end else begin
      if (w_shift) r_bidx  <= r_bidx + 32'd1;
      if (w_match) begin
        r_count <= r_count + 32'd1;
`ifdef PMP_LASTPOS_EN
        r_lastpos <= r_bidx - 32'd1;
`endif
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL:   w_rdata = {21'b0, r_len_m1, 5'b0, r_run, 2'b0};
        OFF_PAT_LO: w_rdata = r_pat_lo;
        OFF_PAT_HI: w_rdata = r_pat_hi;
        OFF_STATUS: w_rdata = {16'b0, 8'(r_cnt), 4'b0, r_ovf, w_empty, w_full, w_busy};
        OFF_COUNT:  w_rdata = r_count;
`ifdef PMP_LASTPOS_EN
        OFF_LASTPOS: w_rdata = r_lastpos;
`endif
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.drdata = w_rdata;
endmodule

// File: tb/tb_pmp_controller.sv
// Directed bench for pmp_controller: reads push expected values to a queue,
// a negedge monitor pops and compares against drdata.
module tb_pmp_controller;
  localparam logic [31:0] BASE = 32'h0000_0500;
  localparam int DEPTH = 8;
`ifdef PMP_LASTPOS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_PLO = BASE + 32'h04,
    A_PHI = BASE + 32'h08, A_TEXT = BASE + 32'h0C, A_STAT = BASE + 32'h10,
    A_CNT = BASE + 32'h14, A_LPOS = BASE + 32'h18;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rd_req = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  pmp_controller_if bus ();

  pmp_controller #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_req) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: drdata=%h with no expected entry", bus.drdata);
      end else begin
        logic [31:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        if (bus.drdata !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", nm, bus.drdata, e);
        end
      end
    end
  end

  function automatic logic [31:0] lp(input logic [31:0] v);
    return LP_EN ? v : 32'h0;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.daddr = a; bus.dwdata = d; bus.dwe = 4'hF;
    @(posedge clk); #1;
    bus.dwe = 4'h0; bus.daddr = 32'h0; bus.dwdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    bus.daddr = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    bus.daddr = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.daddr = 32'h0; bus.dwdata = 32'h0; bus.dwe = 4'h0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_PLO,  32'h0, "rst_pat_lo");
    rd(A_PHI,  32'h0, "rst_pat_hi");
    rd(A_STAT, 32'h4, "rst_status");
    rd(A_CNT,  32'h0, "rst_count");
    rd(A_LPOS, 32'h0, "rst_lastpos");
    rd(32'h0000_0600, 32'h0, "out_of_window");
    wr(A_PHI, 32'hDEAD_BEEF);
    rd(A_PHI, 32'hDEAD_BEEF, "pat_hi_wr");
    wr(A_PHI, 32'hDEAD_BE00);
    bus.dwe = 4'h3; bus.daddr = A_PHI; bus.dwdata = 32'h1234_5678;
    @(posedge clk); #1; bus.dwe = 4'h0;
    rd(A_PHI, 32'hDEAD_BE00, "partial_dwe_ignored");

    // single-byte pattern with latency check
    wr(A_PLO, 32'h41);
    wr(A_CTRL, 32'h001);
    idle(2);
    wr(A_TEXT, 32'h4142_4141);
    idle(5);
    rd(A_CNT, 32'd2, "single_count_e5");
    rd(A_CNT, 32'd3, "single_count_e6");
    rd(A_LPOS, lp(32'd3), "single_lastpos");
    rd(A_STAT, 32'h5, "single_status_busy");
    wr(A_CTRL, 32'h004);
    idle(2);
    rd(A_STAT, 32'h4, "stop_idle_status");
    rd(A_CTRL, 32'h0, "stop_ctrl");

    // overlapping 3-byte matches across two words
    wr(A_CTRL, 32'h002);
    wr(A_PLO, 32'h0061_6161);
    wr(A_CTRL, 32'h201);
    wr(A_TEXT, 32'h6161_6161);
    wr(A_TEXT, 32'h6161_6161);
    idle(2);
    wr(A_PLO, 32'h1234_5678);
    rd(A_PLO, 32'h0061_6161, "pat_write_busy_ignored");
    rd(A_CTRL, 32'h204, "ctrl_len_run");
    idle(15);
    rd(A_CNT, 32'd6, "overlap_count");
    rd(A_LPOS, lp(32'd7), "overlap_lastpos");
    wr(A_CTRL, 32'h004);
    idle(3);

    // overflow: DEPTH+1 words with run=0
    wr(A_CTRL, 32'h002);
    wr(A_PLO, 32'h41);
    wr(A_CTRL, 32'h000);
    for (int i = 0; i <= DEPTH; i++)
      wr(A_TEXT, (i < DEPTH) ? 32'h0000_0041 : 32'h4141_4141);
    rd(A_STAT, 32'h0000_080A, "overflow_status");
    wr(A_CTRL, 32'h001);
    idle(50);
    rd(A_CNT, 32'd8, "overflow_count");
    rd(A_LPOS, lp(32'd28), "overflow_lastpos");
    rd(A_STAT, 32'hD, "overflow_sticky");

    // STOP mid-SCAN then resume
    wr(A_CTRL, 32'h002);
    for (int i = 0; i < 3; i++) wr(A_TEXT, 32'h4141_4141);
    wr(A_CTRL, 32'h001);
    idle(2);
    wr(A_CTRL, 32'h004);
    idle(10);
    rd(A_STAT, 32'h0000_0200, "stop_mid_status");
    rd(A_CNT, 32'd4, "stop_mid_count");
    rd(A_LPOS, lp(32'd3), "stop_mid_lastpos");
    wr(A_CTRL, 32'h001);
    idle(20);
    rd(A_CNT, 32'd12, "resume_count");
    rd(A_LPOS, lp(32'd11), "resume_lastpos");
    rd(A_STAT, 32'h5, "resume_status");

    // CLEAR+START while busy
    wr(A_CTRL, 32'h004);
    idle(3);
    wr(A_CTRL, 32'h201);
    idle(2);
    for (int i = 0; i < 3; i++) wr(A_TEXT, 32'h1111_1111);
    wr(A_CTRL, 32'h503);
    rd(A_CTRL, 32'h200, "clear_ctrl");
    rd(A_STAT, 32'h4, "clear_status");
    rd(A_CNT, 32'h0, "clear_count");
    rd(A_LPOS, 32'h0, "clear_lastpos");
    rd(A_PLO, 32'h41, "clear_keeps_pat_lo");
    rd(A_PHI, 32'hDEAD_BE00, "clear_keeps_pat_hi");

    idle(2);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
